// File: rtl/pc_ctrl_pkg.sv
// Shared types and width helper for the ls163 program-counter sequencer.
package pc_ctrl_pkg;

   // Command opcodes carried on the request bus.
   typedef enum logic [1:0] {
      CMD_CLR  = 2'b00,
      CMD_LOAD = 2'b01,
      CMD_INC  = 2'b10,
      CMD_SKIP = 2'b11
   } cmd_e;

   // Sequencer states.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLR,
      ST_LOAD,
      ST_COUNT,
      ST_DONE
   } state_e;

   localparam int DEF_STAGES = 4;
   localparam int DEF_SKIPW  = 8;

   // Each ls163 contributes four bits to the counter.
   function automatic int ctr_width(input int stages);
      return 4 * stages;
   endfunction

   localparam int DEF_W = ctr_width(DEF_STAGES);

endpackage

// File: rtl/pc_ctrl_if.sv
// Command handshake between the CPU sequencer (master) and pc_ctrl (slave).
interface pc_ctrl_if
   import pc_ctrl_pkg::*;
#(
   parameter int W = DEF_W
);
   logic         CMD_VALID;
   cmd_e         CMD;
   logic [W-1:0] CMD_DATA;
   logic         CMD_READY;
   logic         DONE;
   logic         WRAP;

   modport master (
      output CMD_VALID, CMD, CMD_DATA,
      input  CMD_READY, DONE, WRAP
   );

   modport slave (
      input  CMD_VALID, CMD, CMD_DATA,
      output CMD_READY, DONE, WRAP
   );
endinterface

// File: rtl/pc_ctrl.sv
// Sequencer driving a cascade of ls163 counters: clear, load, increment and
// skip-N commands, with registered strobes/enables and a wrap report.
module pc_ctrl
   import pc_ctrl_pkg::*;
#(
   parameter int STAGES = DEF_STAGES,
   parameter int SKIPW  = DEF_SKIPW,
   localparam int W     = ctr_width(STAGES)
) (
   input  logic         i_CLK,
   input  logic         i_RST,
   pc_ctrl_if.slave     bus,
   output logic         o_CTR_CLR,
   output logic         o_CTR_LOAD,
   output logic         o_CTR_ENP,
   output logic         o_CTR_ENT,
   output logic [W-1:0] o_CTR_D,
   input  logic         i_CTR_RCO
);

   state_e             r_state;
   logic [SKIPW-1:0]   r_cnt;      // steps still to be issued
   logic               r_wrap;     // RCO seen during the current command
   logic [W-1:0]       r_d;
   logic               r_clr_n;
   logic               r_load_n;
   logic               r_en;
   logic               r_ready;
   logic               r_done;
   logic               r_wrap_o;

   state_e             w_state_nxt;
   logic [SKIPW-1:0]   w_cnt_nxt;
   logic               w_wrap_nxt;
   logic [W-1:0]       w_d_nxt;
   logic               w_clr_n_nxt;
   logic               w_load_n_nxt;
   logic               w_en_nxt;
   logic [SKIPW-1:0]   w_skip_n;

   assign w_skip_n = bus.CMD_DATA[SKIPW-1:0];

   // Next-state and next-control decode; controls are one-hot by construction.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_wrap_nxt   = r_wrap;
      w_d_nxt      = r_d;
      w_clr_n_nxt  = 1'b1;
      w_load_n_nxt = 1'b1;
      w_en_nxt     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.CMD_VALID) begin
               w_wrap_nxt = 1'b0;
               case (bus.CMD)
                  CMD_CLR: begin
                     w_state_nxt = ST_CLR;
                     w_clr_n_nxt = 1'b0;
                  end
                  CMD_LOAD: begin
                     w_state_nxt  = ST_LOAD;
                     w_load_n_nxt = 1'b0;
                     w_d_nxt      = bus.CMD_DATA;
                  end
                  CMD_INC: begin
                     w_state_nxt = ST_COUNT;
                     w_cnt_nxt   = SKIPW'(1);
                     w_en_nxt    = 1'b1;
                  end
                  default: begin
                     // Zero-length skip completes without touching the chips.
                     if (w_skip_n == '0) begin
                        w_state_nxt = ST_DONE;
                     end else begin
                        w_state_nxt = ST_COUNT;
                        w_cnt_nxt   = w_skip_n;
                        w_en_nxt    = 1'b1;
                     end
                  end
               endcase
            end
         end
         ST_CLR, ST_LOAD: w_state_nxt = ST_DONE;
         ST_COUNT: begin
            // RCO high with enables on means the chips roll over at this edge.
            if (i_CTR_RCO) w_wrap_nxt = 1'b1;
            w_cnt_nxt = r_cnt - SKIPW'(1);
            if (r_cnt <= SKIPW'(1)) w_state_nxt = ST_DONE;
            else                    w_en_nxt    = 1'b1;
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State and registered outputs; reset idles everything without clearing chips.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_wrap   <= 1'b0;
         r_d      <= '0;
         r_clr_n  <= 1'b1;
         r_load_n <= 1'b1;
         r_en     <= 1'b0;
         r_ready  <= 1'b1;
         r_done   <= 1'b0;
         r_wrap_o <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_wrap   <= w_wrap_nxt;
         r_d      <= w_d_nxt;
         r_clr_n  <= w_clr_n_nxt;
         r_load_n <= w_load_n_nxt;
         r_en     <= w_en_nxt;
         r_ready  <= (w_state_nxt == ST_IDLE);
         r_done   <= (w_state_nxt == ST_DONE);
         r_wrap_o <= (w_state_nxt == ST_DONE) && w_wrap_nxt;
      end
   end

   assign bus.CMD_READY = r_ready;
   assign bus.DONE      = r_done;
   assign bus.WRAP      = r_wrap_o;
   assign o_CTR_CLR     = r_clr_n;
   assign o_CTR_LOAD    = r_load_n;
   assign o_CTR_ENP     = r_en;
   assign o_CTR_ENT     = r_en;
   assign o_CTR_D       = r_d;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl driving two modelled ls163 chips (W=8).
module tb_pc_ctrl;
   import pc_ctrl_pkg::*;

   localparam int STAGES = 2;
   localparam int W      = 4 * STAGES;

   logic         clk = 1'b0;
   logic         rst;
   logic         ctr_clr, ctr_load, ctr_enp, ctr_ent, ctr_rco;
   logic [W-1:0] ctr_d;
   logic [W-1:0] q = '0;
   logic [STAGES-1:0] stg_ent;
   logic         acc;

   int n_tests = 0;
   int n_fail  = 0;

   pc_ctrl_if #(.W(W)) bus ();

   pc_ctrl #(.STAGES(STAGES), .SKIPW(8)) dut (
      .i_CLK      (clk),
      .i_RST      (rst),
      .bus        (bus),
      .o_CTR_CLR  (ctr_clr),
      .o_CTR_LOAD (ctr_load),
      .o_CTR_ENP  (ctr_enp),
      .o_CTR_ENT  (ctr_ent),
      .o_CTR_D    (ctr_d),
      .i_CTR_RCO  (ctr_rco)
   );

   always #5 clk = ~clk;

   // ls163 cascade: ENT of stage i is RCO of stage i-1.
   always_comb begin
      stg_ent = '0;
      acc     = ctr_ent;
      for (int i = 0; i < STAGES; i++) begin
         stg_ent[i] = acc;
         acc        = acc & (q[4*i +: 4] == 4'hF);
      end
      ctr_rco = acc;
   end

   // ls163 chips: sync clear over load over count.
   always_ff @(posedge clk) begin
      for (int i = 0; i < STAGES; i++) begin
         if (!ctr_clr)                      q[4*i +: 4] <= 4'h0;
         else if (!ctr_load)                q[4*i +: 4] <= ctr_d[4*i +: 4];
         else if (ctr_enp && stg_ent[i])    q[4*i +: 4] <= q[4*i +: 4] + 4'h1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one command, then watch until DONE, counting control activity.
   // lat = edges after the accept edge at which DONE is first visible.
   task automatic do_cmd(input string tag, input cmd_e op, input logic [W-1:0] data,
                         input int exp_lat, input int exp_en, input int exp_clr,
                         input int exp_ld, input logic exp_wrap, input logic [W-1:0] exp_q);
      int lat, en_c, clr_c, ld_c;
      logic wrap, wrap_early;
      lat = -1; en_c = 0; clr_c = 0; ld_c = 0; wrap = 1'b0; wrap_early = 1'b0;
      check({tag, "_ready_in"}, bus.CMD_READY, 1);
      bus.CMD_VALID = 1'b1;
      bus.CMD       = op;
      bus.CMD_DATA  = data;
      tick();
      // Post-accept changes must not matter.
      bus.CMD_VALID = 1'b0;
      bus.CMD       = CMD_CLR;
      bus.CMD_DATA  = 8'h5A;
      for (int k = 0; k < 300; k++) begin
         if (bus.DONE) begin
            lat  = k;
            wrap = bus.WRAP;
            break;
         end
         if (bus.WRAP) wrap_early = 1'b1;
         if (ctr_enp && ctr_ent) en_c++;
         if (!ctr_clr)  clr_c++;
         if (!ctr_load) ld_c++;
         tick();
      end
      check({tag, "_lat"},   lat,   exp_lat);
      check({tag, "_en"},    en_c,  exp_en);
      check({tag, "_clr"},   clr_c, exp_clr);
      check({tag, "_ld"},    ld_c,  exp_ld);
      check({tag, "_wrap"},  wrap,  exp_wrap);
      check({tag, "_wrap_early"}, wrap_early, 0);
      check({tag, "_q"},     q,     exp_q);
      tick();
      check({tag, "_idle"},  {bus.CMD_READY, bus.DONE, bus.WRAP}, 3'b100);
   endtask

   initial begin
      int gap, en_c, pulses;
      logic done_seen;
      rst           = 1'b1;
      bus.CMD_VALID = 1'b0;
      bus.CMD       = CMD_CLR;
      bus.CMD_DATA  = '0;
      tick(); tick();
      check("rst_ctl", {bus.CMD_READY, bus.DONE, bus.WRAP, ctr_clr, ctr_load, ctr_enp, ctr_ent},
            7'b1001100);
      check("rst_d", ctr_d, 0);
      rst = 1'b0;
      tick();

      do_cmd("load_a5", CMD_LOAD, 8'hA5, 1, 0, 0, 1, 1'b0, 8'hA5);

      // Reset must leave the chips alone.
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      check("rst_keep_q", q, 8'hA5);
      check("rst_keep_ctl", {bus.CMD_READY, ctr_clr, ctr_load, ctr_enp, ctr_ent}, 5'b11100);
      tick();

      do_cmd("clr",      CMD_CLR,  8'h00, 1, 0, 1, 0, 1'b0, 8'h00);
      do_cmd("load_ff",  CMD_LOAD, 8'hFF, 1, 0, 0, 1, 1'b0, 8'hFF);
      do_cmd("inc_wrap", CMD_INC,  8'h00, 1, 1, 0, 0, 1'b1, 8'h00);
      do_cmd("load_10",  CMD_LOAD, 8'h10, 1, 0, 0, 1, 1'b0, 8'h10);
      do_cmd("inc_10",   CMD_INC,  8'h00, 1, 1, 0, 0, 1'b0, 8'h11);
      do_cmd("load_f0",  CMD_LOAD, 8'hF0, 1, 0, 0, 1, 1'b0, 8'hF0);
      do_cmd("skip20",   CMD_SKIP, 8'd20, 20, 20, 0, 0, 1'b1, 8'h04);
      do_cmd("skip0",    CMD_SKIP, 8'd0,  0, 0, 0, 0, 1'b0, 8'h04);
      do_cmd("clr2",     CMD_CLR,  8'h00, 1, 0, 1, 0, 1'b0, 8'h00);
      // Largest skip stops at all-ones without rolling over.
      do_cmd("skip255",  CMD_SKIP, 8'd255, 255, 255, 0, 0, 1'b0, 8'hFF);
      do_cmd("clr3",     CMD_CLR,  8'h00, 1, 0, 1, 0, 1'b0, 8'h00);

      // Reset mid-skip: accept at a, reset sampled at a+10.
      bus.CMD_VALID = 1'b1; bus.CMD = CMD_SKIP; bus.CMD_DATA = 8'd100;
      tick();
      bus.CMD_VALID = 1'b0;
      repeat (9) tick();
      rst = 1'b1;
      tick();
      check("abort_ctl", {bus.CMD_READY, bus.DONE, ctr_enp, ctr_ent}, 4'b1000);
      check("abort_q", q, 8'h0A);
      rst = 1'b0;
      done_seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (bus.DONE || ctr_enp) done_seen = 1'b1;
      end
      check("abort_nodone", done_seen, 0);
      check("abort_q_hold", q, 8'h0A);

      // Valid held high with changing opcodes while busy on SKIP 5.
      do_cmd("load_40", CMD_LOAD, 8'h40, 1, 0, 0, 1, 1'b0, 8'h40);
      bus.CMD_VALID = 1'b1; bus.CMD = CMD_SKIP; bus.CMD_DATA = 8'd5;
      tick();
      gap = 0; en_c = 0; pulses = 0; done_seen = 1'b0;
      for (int k = 0; k < 40 && !bus.CMD_READY; k++) begin
         bus.CMD      = k[0] ? CMD_LOAD : CMD_CLR;
         bus.CMD_DATA = 8'h77;
         if (ctr_enp && ctr_ent) en_c++;
         if (!ctr_clr || !ctr_load) pulses++;
         if (bus.DONE) begin
            done_seen = 1'b1;
            check("b2b_q_skip", q, 8'h45);
         end
         tick();
         gap++;
      end
      check("b2b_done", done_seen, 1);
      check("b2b_en", en_c, 5);
      check("b2b_no_strobe", pulses, 0);
      bus.CMD = CMD_LOAD; bus.CMD_DATA = 8'h33;
      tick();
      gap++;
      // Accept-to-accept spacing: 1 + 5 + 1 edges.
      check("b2b_spacing", gap, 7);
      bus.CMD_VALID = 1'b0;
      check("b2b_busy", bus.CMD_READY, 0);
      done_seen = 1'b0;
      for (int k = 0; k < 10 && !done_seen; k++) begin
         if (bus.DONE) done_seen = 1'b1;
         else tick();
      end
      check("b2b_load_done", done_seen, 1);
      check("b2b_q_load", q, 8'h33);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
